// File: rtl/fetch_stall_responder_if.sv
// Fetch <-> stall-control / program-memory bus for fetch_stall_responder.
// The slave modport is the fetch block; master is the surrounding pipeline.
interface fetch_stall_responder_if #(
  parameter int INSTR_W = 32,
  parameter int ADDR_W  = 8
);
  logic               stall;
  logic               stall_pm;
  logic               jmp_en;
  logic [ADDR_W-1:0]  jmp_addr;
  logic [INSTR_W-1:0] ins_pm;
  logic [ADDR_W-1:0]  pm_addr;
  logic [INSTR_W-1:0] ins;
  logic [5:0]         op;
  logic               halted;

  modport master (
    output stall, stall_pm, jmp_en, jmp_addr, ins_pm,
    input  pm_addr, ins, op, halted
  );

  modport slave (
    input  stall, stall_pm, jmp_en, jmp_addr, ins_pm,
    output pm_addr, ins, op, halted
  );
endinterface

// File: rtl/fetch_stall_responder.sv
// Instruction-fetch front end: owns the PC, replays the held word on stall_pm, applies jumps, freezes on halt.
// Optional stall-cycle performance counter enabled by defining FETCH_STALL_PERF_CNT_EN.
module fetch_stall_responder #(
  parameter int                 INSTR_W  = 32,
  parameter int                 ADDR_W   = 8,
  parameter logic [INSTR_W-1:0] NOP_WORD = '0
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_stall_responder_if.slave bus
`ifdef FETCH_STALL_PERF_CNT_EN
  ,
  output logic [15:0]            stall_cycles
`endif
);

  localparam logic [5:0] HALT_OP = 6'b010001;

  typedef enum logic [1:0] {
    BOOT = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [ADDR_W-1:0]  pc;
  logic [ADDR_W-1:0]  pc_next;
  logic [INSTR_W-1:0] hold;
  logic [INSTR_W-1:0] hold_next;
  logic [INSTR_W-1:0] ins_mux;
  logic [5:0]         op_cur;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= BOOT;
      pc    <= '0;
      hold  <= NOP_WORD;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      hold  <= hold_next;
    end
  end

  // Only stall_pm and the memory word reach ins; stall never does.
  always_comb begin
    ins_mux = NOP_WORD;
    if (state == RUN) begin
      ins_mux = bus.stall_pm ? hold : bus.ins_pm;
    end
  end

  assign op_cur      = ins_mux[INSTR_W-1 -: 6];
  assign bus.ins     = ins_mux;
  assign bus.op      = op_cur;
  assign bus.pm_addr = pc;
  assign bus.halted  = (state == HALT);

  always_comb begin
    state_next = state;
    pc_next    = pc;
    hold_next  = hold;
    case (state)
      BOOT: begin
        pc_next    = ADDR_W'(1);
        state_next = RUN;
      end
      RUN: begin
        if (!bus.stall_pm) begin
          hold_next = bus.ins_pm;
        end
        // Halt entry outranks a simultaneous jump; jump outranks a plain stall.
        if (bus.stall && (op_cur == HALT_OP)) begin
          state_next = HALT;
        end else if (bus.jmp_en) begin
          pc_next = bus.jmp_addr;
        end else if (!bus.stall) begin
          pc_next = pc + ADDR_W'(1);
        end
      end
      HALT: begin
        state_next = HALT;
      end
      default: begin
        state_next = BOOT;
        pc_next    = '0;
      end
    endcase
  end

`ifdef FETCH_STALL_PERF_CNT_EN
  logic [15:0] stall_count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_count <= '0;
    end else if ((state == RUN) && bus.stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign stall_cycles = stall_count;
`endif

endmodule
